huffman_decoder: RTL and testbench

Receive-side counterpart of the Huffman encoder chain. It accepts the serial, MSB-first code bitstream (start/data/done framing identical to the encoder's serial output) and emits decoded 4-bit symbols. A codeword table is loaded over a simple write port before each frame; the table carries symbol, code and length for up to 10 symbols. The block sits at the end of the decode path, feeding downstream symbol consumers.

---
 rtl/huffman_pkg.sv | 32 +++
 rtl/huffman_decoder_if.sv | 27 ++
 rtl/huffman_match.sv | 27 ++
 rtl/huffman_decoder.sv | 166 ++++++++++++++++
 tb/tb_huffman_decoder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/huffman_pkg.sv
// Shared types and sizes for the Huffman decode path.
package huffman_pkg;

    localparam int unsigned NSYM   = 10;
    localparam int unsigned MAXLEN = 9;
    localparam int unsigned SYM_W  = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned CODE_W = 9;

    // One codeword table entry; len == 0 marks the entry unused.
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
    } huff_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_FLUSH  = 2'd2
    } huff_state_t;

    // Mask covering the low len bits of a codeword.
    function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < CODE_W; b++) begin
            m[b] = (b < 32'(len));
        end
        return m;
    endfunction

endpackage

// File: rtl/huffman_decoder_if.sv
// Table-write, serial-bitstream and decoded-symbol signals of the decoder.
interface huffman_decoder_if;
    import huffman_pkg::*;

    logic              tbl_wr;
    logic [SYM_W-1:0]  tbl_sym;
    logic [CODE_W-1:0] tbl_code;
    logic [LEN_W-1:0]  tbl_len;
    logic              in_start;
    logic              in_data;
    logic              in_done;
    logic              out_valid;
    logic [SYM_W-1:0]  out_sym;
    logic              out_done;
    logic              err;
    logic              busy;

    modport master (
        output tbl_wr, tbl_sym, tbl_code, tbl_len, in_start, in_data, in_done,
        input  out_valid, out_sym, out_done, err, busy
    );

    modport slave (
        input  tbl_wr, tbl_sym, tbl_code, tbl_len, in_start, in_data, in_done,
        output out_valid, out_sym, out_done, err, busy
    );
endinterface

// File: rtl/huffman_match.sv
// Combinational codeword search: finds the lowest-index entry whose length
// equals the bits collected so far and whose code equals those bits.
module huffman_match
    import huffman_pkg::*;
(
    input  huff_entry_t       tbl_i [NSYM],
    input  logic [CODE_W-1:0] acc_n_i,
    input  logic [LEN_W-1:0]  cnt_n_i,
    output logic              hit_o,
    output logic [SYM_W-1:0]  idx_o
);

    // Scan from the top down so the lowest matching index is the one kept.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NSYM - 1; i >= 0; i--) begin
            if ((tbl_i[i].len != '0) && (tbl_i[i].len == cnt_n_i) &&
                ((tbl_i[i].code & len_mask(tbl_i[i].len)) ==
                 (acc_n_i & len_mask(tbl_i[i].len)))) begin
                hit_o = 1'b1;
                idx_o = SYM_W'(i);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder with a loadable codeword table.
// Optional feature macro: HUFFDEC_ERR_EN (overflow/trailing-bit err pulse
// plus an 8-bit saturating err_cnt_q); when undefined err is tied low.
module huffman_decoder
    import huffman_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    huffman_decoder_if.slave bus
);

    huff_state_t         state_q, state_d;
    logic [CODE_W-2:0]   acc_q, acc_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    huff_entry_t         tbl_q [NSYM];
    logic                out_valid_q, out_valid_d;
    logic [SYM_W-1:0]    out_sym_q, out_sym_d;
    logic                out_done_q, out_done_d;
    logic                busy_q, busy_d;

    logic                start_c;
    logic                active_c;
    logic                tbl_we_c;
    logic [CODE_W-2:0]   acc_base_c;
    logic [LEN_W-1:0]    cnt_base_c;
    logic [CODE_W-1:0]   acc_n_c;
    logic [LEN_W-1:0]    cnt_n_c;
    logic                hit_c;
    logic [SYM_W-1:0]    idx_c;
    logic                overflow_c;

`ifdef HUFFDEC_ERR_EN
    logic                err_q, err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
`endif

    // Next shift-register contents; a start bit discards any partial code.
    always_comb begin
        start_c    = bus.in_start && (state_q != ST_FLUSH);
        active_c   = start_c || (state_q == ST_DECODE);
        acc_base_c = start_c ? '0 : acc_q;
        cnt_base_c = start_c ? '0 : cnt_q;
        acc_n_c    = {acc_base_c, bus.in_data};
        cnt_n_c    = cnt_base_c + LEN_W'(1);
        overflow_c = (cnt_n_c == LEN_W'(MAXLEN));
        tbl_we_c   = (state_q == ST_IDLE) && bus.tbl_wr && !bus.in_start &&
                     (bus.tbl_sym < SYM_W'(NSYM));
    end

    huffman_match u_match (
        .tbl_i   (tbl_q),
        .acc_n_i (acc_n_c),
        .cnt_n_i (cnt_n_c),
        .hit_o   (hit_c),
        .idx_o   (idx_c)
    );

    // Frame FSM, bit accumulation and output next-state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_sym_d   = out_sym_q;
        out_done_d  = 1'b0;
`ifdef HUFFDEC_ERR_EN
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
`endif

        case (state_q)
            ST_IDLE:   if (start_c) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_DECODE;
            ST_FLUSH:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (active_c) begin
            if (hit_c) begin
                out_valid_d = 1'b1;
                out_sym_d   = idx_c;
                acc_d       = '0;
                cnt_d       = '0;
            end else if (overflow_c) begin
                acc_d = '0;
                cnt_d = '0;
`ifdef HUFFDEC_ERR_EN
                err_d = 1'b1;
`endif
            end else begin
                acc_d = acc_n_c[CODE_W-2:0];
                cnt_d = cnt_n_c;
            end

            if (bus.in_done) begin
                state_d    = ST_FLUSH;
                out_done_d = 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
`ifdef HUFFDEC_ERR_EN
                if (!hit_c) err_d = 1'b1;
`endif
            end
        end

`ifdef HUFFDEC_ERR_EN
        if (start_c) err_cnt_d = '0;
        if (err_d && (err_cnt_d != 8'hFF)) err_cnt_d = err_cnt_d + 8'd1;
`endif

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_done_q  <= out_done_d;
            busy_q      <= busy_d;
        end
    end

    // Codeword table storage, written only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSYM; i++) tbl_q[i] <= '0;
        end else if (tbl_we_c) begin
            tbl_q[bus.tbl_sym] <= '{code: bus.tbl_code, len: bus.tbl_len};
        end
    end

`ifdef HUFFDEC_ERR_EN
    // Error pulse and saturating per-frame error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_done  = out_done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder.
module tb_huffman_decoder;
    import huffman_pkg::*;

`ifdef HUFFDEC_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    huffman_decoder_if bus ();

    huffman_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input logic [3:0] sym, input logic [8:0] code, input logic [3:0] len);
        bus.tbl_wr   = 1'b1;
        bus.tbl_sym  = sym;
        bus.tbl_code = code;
        bus.tbl_len  = len;
        step();
        bus.tbl_wr   = 1'b0;
    endtask

    // Present one bit, then check what the decoder reports for it.
    task automatic send_bit(input logic s, input logic d, input logic dn,
                            input logic ev, input logic [3:0] es,
                            input logic ed, input logic ee, input string tag);
        bus.in_start = s;
        bus.in_data  = d;
        bus.in_done  = dn;
        step();
        bus.in_start = 1'b0;
        bus.in_data  = 1'b0;
        bus.in_done  = 1'b0;
        bus.tbl_wr   = 1'b0;
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(ev));
        if (ev) chk({tag, ".sym"}, 32'(bus.out_sym), 32'(es));
        chk({tag, ".done"}, 32'(bus.out_done), 32'(ed));
        chk({tag, ".err"},  32'(bus.err),      32'(ee));
        chk({tag, ".busy"}, 32'(bus.busy),     32'd1);
    endtask

    task automatic idle_step(input string tag);
        step();
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".done"},  32'(bus.out_done),  32'd0);
        chk({tag, ".err"},   32'(bus.err),       32'd0);
        chk({tag, ".busy"},  32'(bus.busy),      32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".sym"},   32'(bus.out_sym),   32'd0);
        chk({tag, ".done"},  32'(bus.out_done),  32'd0);
        chk({tag, ".err"},   32'(bus.err),       32'd0);
        chk({tag, ".busy"},  32'(bus.busy),      32'd0);
    endtask

    task automatic load_std_table();
        tbl_write(4'd0, 9'b0,   4'd1);
        tbl_write(4'd1, 9'b10,  4'd2);
        tbl_write(4'd2, 9'b110, 4'd3);
        tbl_write(4'd3, 9'b111, 4'd3);
        tbl_write(4'd5, 9'b0,   4'd1);  // duplicate of entry 0; index 0 must win
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        n_chk        = 0;
        n_err        = 0;
        bus.tbl_wr   = 1'b0;
        bus.tbl_sym  = '0;
        bus.tbl_code = '0;
        bus.tbl_len  = '0;
        bus.in_start = 1'b0;
        bus.in_data  = 1'b0;
        bus.in_done  = 1'b0;

        #3;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Basic frame: 0 | 10 | 110 | 111
        load_std_table();
        send_bit(1, 0, 0, 1, 4'd0, 0, 0, "f1.b0");
        send_bit(0, 1, 0, 0, 4'd0, 0, 0, "f1.b1");
        send_bit(0, 0, 0, 1, 4'd1, 0, 0, "f1.b2");
        send_bit(0, 1, 0, 0, 4'd0, 0, 0, "f1.b3");
        send_bit(0, 1, 0, 0, 4'd0, 0, 0, "f1.b4");
        send_bit(0, 0, 0, 1, 4'd2, 0, 0, "f1.b5");
        send_bit(0, 1, 0, 0, 4'd0, 0, 0, "f1.b6");
        send_bit(0, 1, 0, 0, 4'd0, 0, 0, "f1.b7");
        send_bit(0, 1, 1, 1, 4'd3, 1, 0, "f1.b8");
        idle_step("f1.end");

        // Single-bit frame
        send_bit(1, 0, 1, 1, 4'd0, 1, 0, "f2.b0");
        idle_step("f2.end");

        // Overflow: table reduced to 0:"0" (plus duplicate at 5)
        tbl_write(4'd1, 9'b0, 4'd0);
        tbl_write(4'd2, 9'b0, 4'd0);
        tbl_write(4'd3, 9'b0, 4'd0);
        send_bit(1, 1, 0, 0, 4'd0, 0, 0, "f3.b0");
        for (int i = 1; i < 8; i++) send_bit(0, 1, 0, 0, 4'd0, 0, 0, $sformatf("f3.b%0d", i));
        send_bit(0, 1, 0, 0, 4'd0, 0, ERR_EN, "f3.b8");
        send_bit(0, 0, 1, 1, 4'd0, 1, 0, "f3.b9");
`ifdef HUFFDEC_ERR_EN
        chk("f3.err_cnt", 32'(dut.err_cnt_q), 32'd1);
`endif
        idle_step("f3.end");

        // Frame ending mid-codeword
        load_std_table();
        send_bit(1, 0, 0, 1, 4'd0, 0, 0, "f4.b0");
        send_bit(0, 1, 0, 0, 4'd0, 0, 0, "f4.b1");
        send_bit(0, 1, 1, 0, 4'd0, 1, ERR_EN, "f4.b2");
`ifdef HUFFDEC_ERR_EN
        chk("f4.err_cnt", 32'(dut.err_cnt_q), 32'd1);
`endif
        idle_step("f4.end");

        // Restart mid-codeword discards partial bits silently
        send_bit(1, 1, 0, 0, 4'd0, 0, 0, "f5.b0");
        send_bit(0, 1, 0, 0, 4'd0, 0, 0, "f5.b1");
        send_bit(1, 0, 0, 1, 4'd0, 0, 0, "f5.b2");
        send_bit(0, 1, 0, 0, 4'd0, 0, 0, "f5.b3");
        send_bit(0, 0, 1, 1, 4'd1, 1, 0, "f5.b4");
`ifdef HUFFDEC_ERR_EN
        chk("f5.err_cnt", 32'(dut.err_cnt_q), 32'd0);
`endif
        idle_step("f5.end");

        // Reset mid-frame clears outputs and table
        send_bit(1, 1, 0, 0, 4'd0, 0, 0, "f6.b0");
        send_bit(0, 0, 0, 1, 4'd1, 0, 0, "f6.b1");
        bus.in_data = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("f6.rst");
        bus.in_data = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk_all_zero("f6.post");

        // Empty table, table write coincident with start is ignored
        bus.tbl_wr   = 1'b1;
        bus.tbl_sym  = 4'd1;
        bus.tbl_code = 9'b1;
        bus.tbl_len  = 4'd1;
        send_bit(1, 1, 1, 0, 4'd0, 1, ERR_EN, "f7.b0");
        idle_step("f7.end");
        send_bit(1, 1, 1, 0, 4'd0, 1, ERR_EN, "f8.b0");
`ifdef HUFFDEC_ERR_EN
        chk("f8.err_cnt", 32'(dut.err_cnt_q), 32'd1);
`endif
        idle_step("f8.end");
        send_bit(1, 0, 1, 0, 4'd0, 1, ERR_EN, "f9.b0");
        idle_step("f9.end");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
